// File: rtl/ssd_pkg.sv
// Shared constants and types for the seven-segment display controller.
package ssd_pkg;

    localparam int unsigned NUM_DIGITS = 4;
    localparam int unsigned DIGIT_W    = 2;
    localparam int unsigned SSD_WORD_W = 32;

    localparam logic [NUM_DIGITS-1:0] AN_OFF = 4'b1111;

    // Index k holds the active-low one-cold anode pattern for digit k.
    localparam logic [NUM_DIGITS-1:0][NUM_DIGITS-1:0] AN_DIGIT = {
        4'b0111, 4'b1011, 4'b1101, 4'b1110
    };

    localparam logic [SSD_WORD_W-1:0] RESET_BUFFER = 32'h0;

    typedef enum logic {
        REQ_CPU = 1'b0,
        REQ_DBG = 1'b1
    } req_id_e;

endpackage

// File: rtl/ssd_display_ctrl_arb.sv
// Two-way round-robin arbiter; the requester not served last wins a tie.
module rr_arb2
    import ssd_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic [1:0] valid_i,
    input  logic       accept_i,
    output logic [1:0] grant_o
);

    req_id_e last_q, last_d;

    always_comb begin
        grant_o[0] = valid_i[0] & (~valid_i[1] | (last_q == REQ_DBG));
        grant_o[1] = valid_i[1] & (~valid_i[0] | (last_q == REQ_CPU));
    end

    always_comb begin
        last_d = last_q;
        if (accept_i) begin
            last_d = grant_o[1] ? REQ_DBG : REQ_CPU;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_q <= REQ_DBG;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/ssd_display_ctrl.sv
// Seven-segment display owner: arbitrated display buffer plus digit scan sequencer.
module ssd_display_ctrl
    import ssd_pkg::*;
#(
    parameter int unsigned REFRESH_BITS    = 16,
    parameter bit          RESET_CHAR_MODE = 1'b1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req0_valid,
    input  logic [SSD_WORD_W-1:0] req0_bits,
    input  logic                  req0_char_mode,
    output logic                  req0_ready,
    input  logic                  req1_valid,
    input  logic [SSD_WORD_W-1:0] req1_bits,
    input  logic                  req1_char_mode,
    output logic                  req1_ready,
    input  logic                  blank,
    output logic [SSD_WORD_W-1:0] ssd_bits,
    output logic                  ssd_char_mode,
    output logic [DIGIT_W-1:0]    digit_sel,
    output logic [NUM_DIGITS-1:0] an
);

    logic [1:0] valid;
    logic [1:0] grant;
    logic       accept;

    logic [SSD_WORD_W-1:0]   bits_q, bits_d;
    logic                    mode_q, mode_d;
    logic [REFRESH_BITS-1:0] presc_q, presc_d;
    logic [DIGIT_W-1:0]      digit_q, digit_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;

    assign valid  = {req1_valid, req0_valid};
    assign accept = |grant;

    rr_arb2 u_arb (
        .clk_i    (clk),
        .rst_ni   (rst_n),
        .valid_i  (valid),
        .accept_i (accept),
        .grant_o  (grant)
    );

    // Gated by rst_n so no request sees ready while reset is asserted.
    assign req0_ready = grant[0] & rst_n;
    assign req1_ready = grant[1] & rst_n;

    always_comb begin
        bits_d = bits_q;
        mode_d = mode_q;
        if (grant[1]) begin
            bits_d = req1_bits;
            mode_d = req1_char_mode;
        end else if (grant[0]) begin
            bits_d = req0_bits;
            mode_d = req0_char_mode;
        end
    end

    always_comb begin
        presc_d = presc_q + 1'b1;
        digit_d = digit_q;
        if (&presc_q) begin
            digit_d = digit_q + 1'b1;
        end
        an_d = blank ? AN_OFF : AN_DIGIT[digit_q];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bits_q  <= RESET_BUFFER;
            mode_q  <= RESET_CHAR_MODE;
            presc_q <= '0;
            digit_q <= '0;
            an_q    <= AN_OFF;
        end else begin
            bits_q  <= bits_d;
            mode_q  <= mode_d;
            presc_q <= presc_d;
            digit_q <= digit_d;
            an_q    <= an_d;
        end
    end

    assign ssd_bits      = bits_q;
    assign ssd_char_mode = mode_q;
    assign digit_sel     = digit_q;
    assign an            = an_q;

endmodule

// File: tb/tb_ssd_display_ctrl.sv
// Randomized bench for ssd_display_ctrl against a cycle-count based reference model.
module tb_ssd_display_ctrl;

    localparam int RB     = 2;
    localparam int PERIOD = 1 << RB;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        req0_valid, req0_char_mode, req0_ready;
    logic [31:0] req0_bits;
    logic        req1_valid, req1_char_mode, req1_ready;
    logic [31:0] req1_bits;
    logic        blank;
    logic [31:0] ssd_bits;
    logic        ssd_char_mode;
    logic [1:0]  digit_sel;
    logic [3:0]  an;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference state: cycles since reset release, who was served last, buffer, anodes.
    int          m_cyc;
    int          m_last;
    logic [31:0] m_bits;
    logic        m_mode;
    logic [3:0]  m_an;

    ssd_display_ctrl #(.REFRESH_BITS(RB), .RESET_CHAR_MODE(1'b1)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .req0_valid     (req0_valid),
        .req0_bits      (req0_bits),
        .req0_char_mode (req0_char_mode),
        .req0_ready     (req0_ready),
        .req1_valid     (req1_valid),
        .req1_bits      (req1_bits),
        .req1_char_mode (req1_char_mode),
        .req1_ready     (req1_ready),
        .blank          (blank),
        .ssd_bits       (ssd_bits),
        .ssd_char_mode  (ssd_char_mode),
        .digit_sel      (digit_sel),
        .an             (an)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_digit(input int c);
        return (c / PERIOD) % 4;
    endfunction

    function automatic logic [3:0] onecold(input int d);
        logic [3:0] one;
        one = 4'b0001 << d;
        return ~one;
    endfunction

    task automatic model_reset();
        m_cyc  = 0;
        m_last = 1;
        m_bits = 32'h0;
        m_mode = 1'b1;
        m_an   = 4'b1111;
    endtask

    // Called at a negedge with inputs driven; ends at the following negedge.
    task automatic step(output int win);
        #1;
        win = -1;
        if (req0_valid && req1_valid) win = (m_last == 0) ? 1 : 0;
        else if (req0_valid)          win = 0;
        else if (req1_valid)          win = 1;
        check("req0_ready", {31'b0, req0_ready}, {31'b0, win == 0});
        check("req1_ready", {31'b0, req1_ready}, {31'b0, win == 1});
        check("digit_pre", {30'b0, digit_sel}, exp_digit(m_cyc));
        if (win == 0) begin m_bits = req0_bits; m_mode = req0_char_mode; m_last = 0; end
        if (win == 1) begin m_bits = req1_bits; m_mode = req1_char_mode; m_last = 1; end
        m_an = blank ? 4'b1111 : onecold(exp_digit(m_cyc));
        m_cyc++;
        @(posedge clk);
        #1;
        check("ssd_bits", ssd_bits, m_bits);
        check("ssd_char_mode", {31'b0, ssd_char_mode}, {31'b0, m_mode});
        check("an", {28'b0, an}, {28'b0, m_an});
        check("digit_sel", {30'b0, digit_sel}, exp_digit(m_cyc));
        @(negedge clk);
    endtask

    initial begin
        int          w;
        int          last_w;
        logic [31:0] r;

        rst_n = 1'b0;
        req0_valid = 1'b0; req0_bits = '0; req0_char_mode = 1'b0;
        req1_valid = 1'b0; req1_bits = '0; req1_char_mode = 1'b0;
        blank = 1'b0;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_bits", ssd_bits, 32'h0);
        check("rst_mode", {31'b0, ssd_char_mode}, 32'h1);
        check("rst_an", {28'b0, an}, 32'hF);
        check("rst_digit", {30'b0, digit_sel}, 32'h0);
        rst_n = 1'b1;

        // Idle scan, then a single CPU write held afterwards.
        repeat (6) step(w);
        req0_valid = 1'b1; req0_bits = 32'h0C0B0A09; req0_char_mode = 1'b1;
        step(w);
        req0_valid = 1'b0; req0_bits = 32'hDEADBEEF;
        repeat (3) step(w);
        check("hold_bits", ssd_bits, 32'h0C0B0A09);

        // Continuous contention must alternate grants.
        req0_valid = 1'b1; req0_bits = 32'h11111111; req0_char_mode = 1'b0;
        req1_valid = 1'b1; req1_bits = 32'h22222222; req1_char_mode = 1'b1;
        last_w = -1;
        repeat (6) begin
            step(w);
            if (last_w >= 0) check("alternate", w, 1 - last_w);
            last_w = w;
        end
        req0_valid = 1'b0; req1_valid = 1'b0;

        // Free run, then a 10-cycle blank window, then resume.
        repeat (20) step(w);
        blank = 1'b1;
        repeat (10) step(w);
        blank = 1'b0;
        repeat (6) step(w);

        // Randomized traffic obeying hold-until-accepted.
        repeat (400) begin
            if (!req0_valid) begin
                req0_valid = ($urandom_range(0, 2) != 0);
                req0_bits = $urandom; r = $urandom; req0_char_mode = r[0];
            end
            if (!req1_valid) begin
                req1_valid = ($urandom_range(0, 2) == 0);
                req1_bits = $urandom; r = $urandom; req1_char_mode = r[0];
            end
            if ($urandom_range(0, 15) == 0) blank = ~blank;
            step(w);
            if (w == 0) req0_valid = 1'b0;
            if (w == 1) req1_valid = 1'b0;
        end
        req0_valid = 1'b0; req1_valid = 1'b0; blank = 1'b0;

        // Reset in the middle of a cycle with a CPU request pending.
        req1_valid = 1'b1; req1_bits = 32'hFFFF0000; req1_char_mode = 1'b0;
        step(w);
        req1_valid = 1'b0;
        req0_valid = 1'b1; req0_bits = 32'h12345678; req0_char_mode = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("mid_rst_ready0", {31'b0, req0_ready}, 32'h0);
        check("mid_rst_bits", ssd_bits, 32'h0);
        check("mid_rst_an", {28'b0, an}, 32'hF);
        check("mid_rst_digit", {30'b0, digit_sel}, 32'h0);
        @(posedge clk);
        #1;
        check("rst_hold_ready0", {31'b0, req0_ready}, 32'h0);
        check("rst_hold_bits", ssd_bits, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        model_reset();
        step(w);
        check("post_rst_accept", w, 0);
        req0_valid = 1'b0;
        repeat (8) step(w);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
